// File: rtl/svm_pkg.sv
// Shared types and width helpers for the SVM datapath blocks.
package svm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } denorm_state_t;

    localparam int unsigned DENORM_D_WIDTH = 16;

    // Shift-amount width for a given data width; at least one bit even for tiny words.
    function automatic int unsigned denorm_sh_width(input int unsigned d_width);
        return (d_width > 2) ? $clog2(d_width) : 1;
    endfunction

endpackage

// File: rtl/denorm_shift_seq.sv
// Sequential denormalizer: right-shifts a normalized word one bit per cycle,
// accumulating a sticky bit over everything shifted out.
module denorm_shift_seq
    import svm_pkg::*;
#(
    parameter int unsigned D_WIDTH = DENORM_D_WIDTH,
    localparam int unsigned SH_WIDTH = denorm_sh_width(D_WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [D_WIDTH-1:0]  norm_i,
    input  logic [SH_WIDTH-1:0] shamt_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [D_WIDTH-1:0]  data_o,
    output logic                sticky_o,
    output logic                busy_o
);

    denorm_state_t state_q, state_d;
    logic [D_WIDTH-1:0]  shift_q, shift_d;
    logic                sticky_q, sticky_d;
    logic [SH_WIDTH-1:0] count_q, count_d;
    logic [D_WIDTH-1:0]  data_out_q;
    logic                sticky_out_q;
    logic                load_out;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        sticky_d = sticky_q;
        count_d  = count_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    shift_d  = norm_i;
                    count_d  = shamt_i;
                    sticky_d = 1'b0;
                    state_d  = (shamt_i != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                sticky_d = sticky_q | shift_q[0];
                shift_d  = shift_q >> 1;
                count_d  = count_q - SH_WIDTH'(1);
                if (count_q == SH_WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers load once on entry to DONE so they hold between results.
    assign load_out = (state_q != DONE) && (state_d == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            sticky_q     <= 1'b0;
            count_q      <= '0;
            data_out_q   <= '0;
            sticky_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            if (load_out) begin
                data_out_q   <= shift_d;
                sticky_out_q <= sticky_d;
            end
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign data_o      = data_out_q;
    assign sticky_o    = sticky_out_q;

endmodule

// File: tb/tb_denorm_shift_seq.sv
// Randomized self-checking bench for denorm_shift_seq with a transaction-level model.
module tb_denorm_shift_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] norm_i = '0;
    logic [3:0]  shamt_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] data_o;
    logic        sticky_o;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    denorm_shift_seq #(.D_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .norm_i     (norm_i),
        .shamt_i    (shamt_i),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .data_o     (data_o),
        .sticky_o   (sticky_o),
        .busy_o     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding word, result visible 1+shamt edges after accept.
    logic        m_pending = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [15:0] m_data = '0;
    logic        m_sticky = 1'b0;
    logic        m_valid;

    assign m_valid = m_pending && (m_age >= m_lat);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_age     <= 0;
        end else if (!m_pending) begin
            if (in_valid) begin
                m_pending <= 1'b1;
                m_age     <= 1;
                m_lat     <= int'(shamt_i) + 1;
                m_data    <= norm_i >> shamt_i;
                m_sticky  <= |(norm_i & ((16'd1 << shamt_i) - 16'd1));
            end
        end else if (m_age >= m_lat) begin
            if (out_ready) m_pending <= 1'b0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
        end else begin
            check("in_ready", 32'(in_ready), 32'(!m_pending));
            check("busy", 32'(busy), 32'(m_pending));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("data", 32'(data_o), 32'(m_data));
                check("sticky", 32'(sticky_o), 32'(m_sticky));
            end
        end
    end

    // One transaction with literal expectations; hold = extra cycles out_ready stays low.
    task automatic send(input logic [15:0] norm, input logic [3:0] sh, input int hold,
                        input logic [15:0] ed, input logic es, input int el, input bit pulse);
        int  n;
        bit  ok;
        @(posedge clk);
        #2;
        in_valid  = 1'b1;
        norm_i    = norm;
        shamt_i   = sh;
        out_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        norm_i   = 16'($urandom);
        n  = 1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            if (pulse && n == 2) begin
                in_valid = 1'b1;
                norm_i   = 16'h5555;
                shamt_i  = 4'd1;
            end else begin
                in_valid = 1'b0;
            end
            n++;
        end
        in_valid = 1'b0;
        check("valid_timeout", 32'(ok), 32'd1);
        check("latency", 32'(n), 32'(el));
        check("lit_data", 32'(data_o), 32'(ed));
        check("lit_sticky", 32'(sticky_o), 32'(es));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(data_o), 32'(ed));
            check("hold_sticky", 32'(sticky_o), 32'(es));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic back_to_back();
        int  acc;
        int  hs_cyc;
        int  acc2;
        bit  r;
        bit  v;
        bit  ok;
        acc    = 0;
        hs_cyc = -1;
        acc2   = -1;
        @(posedge clk);
        #2;
        in_valid  = 1'b1;
        norm_i    = 16'hABCD;
        shamt_i   = 4'd2;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            r = in_ready;
            v = out_valid;
            if (v && hs_cyc < 0) begin
                check("b2b_a_data", 32'(data_o), 32'h2AF3);
                check("b2b_a_sticky", 32'(sticky_o), 32'd1);
            end
            @(posedge clk);
            if (v && hs_cyc < 0) hs_cyc = cyc;
            if (r) begin
                acc++;
                if (acc == 1) begin
                    #2 norm_i = 16'h0F0C;
                end else begin
                    acc2 = cyc;
                    #2 in_valid = 1'b0;
                    break;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_second_accept", 32'(acc2 >= 0), 32'd1);
        check("b2b_bubble", 32'(acc2 - hs_cyc), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b_b_timeout", 32'(ok), 32'd1);
        check("b2b_b_data", 32'(data_o), 32'h03C3);
        check("b2b_b_sticky", 32'(sticky_o), 32'd0);
        @(posedge clk);
        #2;
        out_ready = 1'b0;
    endtask

    task automatic reset_mid_shift();
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        norm_i   = 16'h1234;
        shamt_i  = 4'd10;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("no_valid_after_rst", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] nv;
        logic [3:0]  sv;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_data", 32'(data_o), 32'd0);

        send(16'h8000, 4'd3, 0, 16'h1000, 1'b0, 4, 1'b0);
        send(16'hB001, 4'd4, 0, 16'h0B00, 1'b1, 5, 1'b0);
        send(16'h1234, 4'd0, 0, 16'h1234, 1'b0, 1, 1'b0);
        send(16'hFFFF, 4'd15, 5, 16'h0001, 1'b1, 16, 1'b1);
        send(16'h0000, 4'd7, 1, 16'h0000, 1'b0, 8, 1'b0);
        back_to_back();
        reset_mid_shift();
        send(16'hB001, 4'd4, 0, 16'h0B00, 1'b1, 5, 1'b0);

        for (int t = 0; t < 40; t++) begin
            nv = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            sv = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(nv, sv, $urandom_range(0, 3), nv >> sv,
                 |(nv & ((16'd1 << sv) - 16'd1)), int'(sv) + 1, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
